// File: rtl/apb_master_pkg.sv
// Shared constants for the APB requester: FSM state codes, APB phase
// encodings and the strobe-width helper.
package apb_master_pkg;

    // FSM state codes (2-bit, kept as plain constants for legacy tools).
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // APB phase encodings as {psel, penable}.
    localparam logic [1:0] PH_IDLE   = 2'b00;
    localparam logic [1:0] PH_SETUP  = 2'b10;
    localparam logic [1:0] PH_ACCESS = 2'b11;

    // One strobe bit per data byte.
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB4 bus, bundled for the requester.
// The master modport is the requester's view; slave is the opposite side.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import apb_master_pkg::*;

    localparam int STRB_W = strb_width(DATA_W);

    // Local controller command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;

    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB4 bus
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_master_wait_timer.sv
// Wait-state counter for the ACCESS phase. Counts pready-low cycles,
// saturates at TIMEOUT, and flags the cycle that would reach TIMEOUT.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count wait cycles; clear wins, and the count holds once it saturates.
    // NOTE: registered state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + CW'(1);
        end
    end

    // This wait cycle is the TIMEOUT-th consecutive one.
    assign expired = enable && (count >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB4 requester: turns one outstanding command into SETUP/ACCESS phases,
// captures the completion and holds a response until it is consumed.
// Slave wait states are bounded by TIMEOUT.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    apb_master_if.master  bus
);
    localparam int STRB_W = strb_width(DATA_W);

    logic [1:0]        state;
    logic              psel_q;
    logic              penable_q;
    // The bus field registers double as the command buffer: they are
    // loaded at accept and held until the next accept.
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    logic              accept;
    logic              wait_en;
    logic              wait_expired;

    assign accept  = (state == ST_IDLE) && bus.cmd_valid;
    assign wait_en = (state == ST_ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (wait_en),
        .expired (wait_expired)
    );

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            {psel_q, penable_q}  <= PH_IDLE;
            pwrite_q             <= 1'b0;
            paddr_q              <= '0;
            pwdata_q             <= '0;
            pstrb_q              <= '0;
            rsp_valid_q          <= 1'b0;
            rsp_rdata_q          <= '0;
            rsp_err_q            <= 1'b0;
            rsp_timeout_q        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        state               <= ST_SETUP;
                        {psel_q, penable_q} <= PH_SETUP;
                        pwrite_q            <= bus.cmd_write;
                        paddr_q             <= bus.cmd_addr;
                        // Reads carry no write data and no strobes on APB4.
                        pwdata_q            <= bus.cmd_write ? bus.cmd_wdata : '0;
                        pstrb_q             <= bus.cmd_write ? bus.cmd_strb  : '0;
                    end
                end
                ST_SETUP: begin
                    state               <= ST_ACCESS;
                    {psel_q, penable_q} <= PH_ACCESS;
                end
                ST_ACCESS: begin
                    // Completion is checked first so pready on the last
                    // allowed wait cycle still finishes normally.
                    if (bus.pready) begin
                        state               <= ST_RESP;
                        {psel_q, penable_q} <= PH_IDLE;
                        rsp_valid_q         <= 1'b1;
                        rsp_err_q           <= bus.pslverr;
                        rsp_timeout_q       <= 1'b0;
                        rsp_rdata_q         <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                    end else if (wait_expired) begin
                        state               <= ST_RESP;
                        {psel_q, penable_q} <= PH_IDLE;
                        rsp_valid_q         <= 1'b1;
                        rsp_err_q           <= 1'b1;
                        rsp_timeout_q       <= 1'b1;
                        rsp_rdata_q         <= '0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        rsp_valid_q   <= 1'b0;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // cmd_ready is the only combinational output: a decode of IDLE.
    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus pushes slave plans and expected
// responses; an APB slave model and a response monitor check independently.
module tb_apb_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int TIMEOUT = 4;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;   // ACCESS cycles with pready low before completion
        bit          err;     // pslverr presented with pready
        logic [31:0] rdata;   // prdata presented with pready
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          to;
        int          due;     // clock edge after which rsp_valid first shows
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   hold_left = 0;
    bit   rnd_ready = 1'b0;

    txn_t plan_q[$];
    exp_t exp_q[$];

    apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (edge %0d)", name, cyc);
    endtask

    // Reference model: response contents and arrival edge from the protocol rules.
    function automatic exp_t model(input txn_t t, input int accept_edge);
        exp_t e;
        if (t.waits >= TIMEOUT) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
            e.to    = 1'b1;
            e.due   = accept_edge + 1 + TIMEOUT;
        end else begin
            e.err   = t.err;
            e.to    = 1'b0;
            e.rdata = (!t.write && !t.err) ? t.rdata : 32'h0;
            e.due   = accept_edge + 2 + t.waits;
        end
        return e;
    endfunction

    function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int waits, input bit err,
                                input logic [31:0] rd);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = d; t.strb = s;
        t.waits = waits; t.err = err; t.rdata = rd;
        return t;
    endfunction

    function automatic txn_t rnd_txn();
        return mk(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, TIMEOUT + 1),
                  ($urandom_range(0, 3) == 0), $urandom);
    endfunction

    // Present a command, wait for acceptance, then record plan and expectation.
    task automatic issue(input txn_t t, input bit drop);
        int guard;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = t.write;
        bus.cmd_addr  = t.addr;
        bus.cmd_wdata = t.wdata;
        bus.cmd_strb  = t.strb;
        guard = 0;
        while (!bus.cmd_ready) begin
            guard++;
            if (guard > 200) begin
                fail_now("cmd_accept_timeout");
                bus.cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        plan_q.push_back(t);
        if (!drop) exp_q.push_back(model(t, cyc + 1));
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 || bus.rsp_valid || !bus.cmd_ready) begin
            guard++;
            if (guard > 500) begin
                fail_now("drain_timeout");
                exp_q.delete();
                return;
            end
            @(negedge clk);
        end
    endtask

    // APB slave model: checks SETUP fields and ACCESS stability, drives pready per plan.
    txn_t s_cur;
    bit   s_have = 1'b0;
    int   s_acc  = 0;
    always @(negedge clk) begin
        if (rst) begin
            s_have      = 1'b0;
            bus.pready  = 1'b0;
            bus.pslverr = 1'b0;
            bus.prdata  = '0;
        end else if (bus.psel && !bus.penable) begin
            if (plan_q.size() == 0) begin
                fail_now("setup_without_command");
            end else begin
                s_cur  = plan_q.pop_front();
                s_have = 1'b1;
                s_acc  = 0;
                check("setup_pwrite", bus.pwrite, s_cur.write);
                check("setup_paddr", bus.paddr, s_cur.addr);
                check("setup_pwdata", bus.pwdata, s_cur.write ? s_cur.wdata : 32'h0);
                check("setup_pstrb", bus.pstrb, s_cur.write ? s_cur.strb : 4'h0);
            end
            bus.pready  = 1'b0;
            bus.pslverr = 1'($urandom);
            bus.prdata  = $urandom;
        end else if (bus.psel && bus.penable) begin
            if (!s_have) begin
                fail_now("access_without_setup");
            end else begin
                check("access_fields_stable", {bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb},
                      {s_cur.write, s_cur.addr, s_cur.write ? s_cur.wdata : 32'h0,
                       s_cur.write ? s_cur.strb : 4'h0});
                if (s_acc == s_cur.waits) begin
                    bus.pready  = 1'b1;
                    bus.pslverr = s_cur.err;
                    bus.prdata  = s_cur.rdata;
                end else begin
                    // pslverr and prdata are noise while pready is low.
                    bus.pready  = 1'b0;
                    bus.pslverr = 1'($urandom);
                    bus.prdata  = $urandom;
                end
                s_acc++;
            end
        end else begin
            bus.pready  = 1'($urandom);
            bus.pslverr = 1'($urandom);
            bus.prdata  = $urandom;
        end
    end

    // Response consumer: optional forced stall, otherwise random or always ready.
    always @(posedge clk) begin
        #2;
        if (bus.rsp_valid && hold_left > 0) begin
            bus.rsp_ready = 1'b0;
            hold_left--;
        end else if (bus.rsp_valid) begin
            bus.rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
            bus.rsp_ready = 1'($urandom);
        end
    end

    // Response monitor: pops the scoreboard on each new response.
    exp_t m_cur;
    bit   m_in = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            m_in = 1'b0;
        end else if (bus.rsp_valid) begin
            check("resp_cmd_ready_low", bus.cmd_ready, 1'b0);
            if (!m_in) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    m_cur = exp_q.pop_front();
                    m_in  = 1'b1;
                    check("rsp_rdata", bus.rsp_rdata, m_cur.rdata);
                    check("rsp_err", bus.rsp_err, m_cur.err);
                    check("rsp_timeout", bus.rsp_timeout, m_cur.to);
                    check("rsp_arrival_edge", cyc, m_cur.due);
                    check("resp_bus_released", {bus.psel, bus.penable}, 2'b00);
                end
            end else begin
                check("rsp_hold_stable", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
                      {m_cur.rdata, m_cur.err, m_cur.to});
            end
            if (bus.rsp_ready) m_in = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err,
                             bus.rsp_timeout}, 6'b0);
        check("reset_data", {bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata}, 100'h0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_reset", bus.cmd_ready, 1'b1);

        // Directed cases
        issue(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'hA5A5_5A5A), 1'b0);
        issue(mk(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h1234_5678), 1'b0);
        issue(mk(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h7777_7777), 1'b0);
        issue(mk(1'b0, 32'h0000_0040, 32'h0, 4'hF, TIMEOUT, 1'b0, 32'hCAFE_0001), 1'b0);
        issue(mk(1'b0, 32'h0000_0044, 32'h0, 4'hF, TIMEOUT - 1, 1'b0, 32'hCAFE_0002), 1'b0);
        issue(mk(1'b1, 32'h0000_0048, 32'h1111_2222, 4'h5, TIMEOUT + 2, 1'b1, 32'h0), 1'b0);
        drain();

        // Stalled response with the next command already waiting
        hold_left = 5;
        issue(mk(1'b0, 32'h0000_0050, 32'h0, 4'hF, 0, 1'b0, 32'h5555_AAAA), 1'b0);
        issue(mk(1'b1, 32'h0000_0054, 32'h8765_4321, 4'hC, 2, 1'b0, 32'h0), 1'b0);
        drain();

        // Randomized traffic with a randomly stalling consumer
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(rnd_txn(), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rnd_ready = 1'b0;

        // Reset in the middle of ACCESS: bus drops at once, no response
        issue(mk(1'b1, 32'h0000_0060, 32'h9999_0000, 4'hF, TIMEOUT + 5, 1'b0, 32'h0), 1'b1);
        guard = 0;
        while (!(bus.psel && bus.penable) && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 20) fail_now("access_not_reached");
        #1;
        rst = 1'b1;
        #1;
        check("rst_bus_released", {bus.psel, bus.penable}, 2'b00);
        check("rst_no_response", bus.rsp_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_midreset", bus.cmd_ready, 1'b1);
        issue(mk(1'b1, 32'h0000_0070, 32'h0123_4567, 4'hF, 0, 1'b0, 32'h0), 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
